// File: rtl/energy_histogram.sv
// Purpose : energy-sample histogram; clears NBINS counters, accumulates N_SAMPLES samples, then serves bin reads.
// Latency : an accepted sample's count is in memory two cycles after acceptance; rd_data/rd_valid follow rd_en by one cycle.
// Backpressure: none; samples outside ACCUM are dropped and reads outside IDLE/DONE are ignored.
//
// Ports:
//   clk, rst (async, active low)       single clock domain, all state on rising edge
//   start                               one-cycle pulse, honoured in IDLE/DONE only
//   sample_valid, energy_in             sample stream, bin = energy_in >> BIN_SHIFT
//   busy, done                          busy in CLEAR/ACCUM, done held in DONE
//   rd_en, rd_addr -> rd_data, rd_valid bin read port
//   total_count                         samples accepted in the current run
//   overflow                            sticky saturation flag, present only with HIST_OVERFLOW_FLAG_EN
//
// Optional build macro: HIST_OVERFLOW_FLAG_EN adds the overflow output.
module energy_histogram #(
    parameter int ENG_IN_BITS = 12,
    parameter int BIN_SHIFT   = 2,
    parameter int CNT_BITS    = 24,
    parameter int N_SAMPLES   = 65536
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               sample_valid,
    input  logic [ENG_IN_BITS-1:0]             energy_in,
    output logic                               busy,
    output logic                               done,
    input  logic                               rd_en,
    input  logic [ENG_IN_BITS-BIN_SHIFT-1:0]   rd_addr,
    output logic [CNT_BITS-1:0]                rd_data,
    output logic                               rd_valid,
    output logic [CNT_BITS-1:0]                total_count
`ifdef HIST_OVERFLOW_FLAG_EN
    ,
    output logic                               overflow
`endif
);

    localparam int AW    = ENG_IN_BITS - BIN_SHIFT;
    localparam int NBINS = 1 << AW;

    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    // Compared one bit wider so N_SAMPLES = 2^CNT_BITS still terminates the run.
    localparam logic [CNT_BITS:0]   LAST_CNT = (CNT_BITS+1)'(N_SAMPLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;

    logic [AW-1:0]       clr_idx_q;
    logic                drain_q;
    logic [CNT_BITS-1:0] total_q;

    // Pipeline: s1 = accepted sample (memory read issued), s2 = increment and write.
    logic                s1_vld_q;
    logic [AW-1:0]       s1_idx_q;
    logic                s2_vld_q;
    logic [AW-1:0]       s2_idx_q;
    logic                s2_fwd_q;
    logic [CNT_BITS-1:0] s2_fwd_dat_q;

    logic                rd_vld_q;

    // Bin memory: one read port, one write port.
    logic [CNT_BITS-1:0] mem [NBINS];
    logic [CNT_BITS-1:0] mem_rdata_q;

    logic                run_start;
    logic                accept;
    logic                acc_last;
    logic                rd_ok;
    logic [AW-1:0]       mem_raddr;
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;
    logic [CNT_BITS-1:0] mem_wdat;
    logic [CNT_BITS-1:0] bin_base;
    logic [CNT_BITS-1:0] bin_inc;
    logic [AW-1:0]       sample_bin;

    // The dropped LSBs only matter through the shift below.
    logic                unused_energy;
    assign unused_energy = ^energy_in;

    assign sample_bin = energy_in[ENG_IN_BITS-1:BIN_SHIFT];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (&clr_idx_q) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (acc_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Two cycles: one for the last read, one for the last write.
                if (drain_q) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and qualified strobes
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q == ST_CLEAR) || (state_q == ST_ACCUM);
        done      = (state_q == ST_DONE);
        run_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        accept    = sample_valid && (state_q == ST_ACCUM);
        rd_ok     = rd_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    assign acc_last = accept && ({1'b0, total_q} == LAST_CNT);

    // ------------------------------------------------------------------
    // Run control counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_idx_q <= '0;
            drain_q   <= 1'b0;
            total_q   <= '0;
        end else begin
            if (run_start) begin
                clr_idx_q <= '0;
            end else if (state_q == ST_CLEAR) begin
                clr_idx_q <= clr_idx_q + AW'(1);
            end

            drain_q <= (state_q == ST_DRAIN) ? ~drain_q : 1'b0;

            if (run_start) begin
                total_q <= '0;
            end else if (accept) begin
                total_q <= total_q + CNT_BITS'(1);
            end
        end
    end

    assign total_count = total_q;

    // ------------------------------------------------------------------
    // Read-modify-write pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q     <= 1'b0;
            s1_idx_q     <= '0;
            s2_vld_q     <= 1'b0;
            s2_idx_q     <= '0;
            s2_fwd_q     <= 1'b0;
            s2_fwd_dat_q <= '0;
            rd_vld_q     <= 1'b0;
        end else begin
            s1_vld_q     <= accept;
            s1_idx_q     <= sample_bin;
            s2_vld_q     <= s1_vld_q;
            s2_idx_q     <= s1_idx_q;
            // The read for s1 happens on the same edge as s2's write; if both
            // target one bin the read returns the stale count, so carry the
            // value being written instead.
            s2_fwd_q     <= s1_vld_q && s2_vld_q && (s1_idx_q == s2_idx_q);
            s2_fwd_dat_q <= bin_inc;
            rd_vld_q     <= rd_ok;
        end
    end

    // The pipeline only runs in ACCUM/DRAIN and reads only in IDLE/DONE,
    // so the read address mux never has two real requesters.
    assign mem_raddr = s1_vld_q ? s1_idx_q : rd_addr;

    assign bin_base = s2_fwd_q ? s2_fwd_dat_q : mem_rdata_q;
    assign bin_inc  = (bin_base == CNT_MAX) ? CNT_MAX : bin_base + CNT_BITS'(1);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = s2_idx_q;
        mem_wdat  = bin_inc;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx_q;
            mem_wdat  = '0;
        end else if (s2_vld_q) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdat;
        end
        mem_rdata_q <= mem[mem_raddr];
    end

    // Gated so rd_data is zero whenever no read is being returned, including reset.
    assign rd_valid = rd_vld_q;
    assign rd_data  = rd_vld_q ? mem_rdata_q : '0;

`ifdef HIST_OVERFLOW_FLAG_EN
    // ------------------------------------------------------------------
    // Sticky overflow: set when a write reaches the ceiling or lands on a
    // bin already at the ceiling.
    // ------------------------------------------------------------------
    logic ovf_q;
    logic sat_hit;

    assign sat_hit = s2_vld_q && (bin_base >= (CNT_MAX - CNT_BITS'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (run_start) begin
            ovf_q <= 1'b0;
        end else if (sat_hit) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule
